// File: rtl/fifo8x16_if.sv
// Handshake and status bundle between a producer/consumer and the 8x16 FIFO.
//
// Handshake: push is a write request and in is captured on the rising clk
// edge when the push is accepted (not full, or full with a same-cycle pop).
// pop is a read request and discards the head word (shown on out) on the
// rising clk edge when the FIFO is not empty. There is no ready signal; the
// requester observes full/empty and the sticky ovf/udf flags instead.
interface fifo8x16_if;
    logic [15:0] in;
    logic        push;
    logic        pop;
    logic [15:0] out;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        ovf;
    logic        udf;

    // Producer/consumer side
    modport master (
        output in, push, pop,
        input  out, empty, full, count, ovf, udf
    );

    // FIFO side
    modport slave (
        input  in, push, pop,
        output out, empty, full, count, ovf, udf
    );
endinterface

// File: rtl/fifo8x16.sv
// 8-entry, 16-bit synchronous show-ahead FIFO. The head word is read through
// an 8:1 mux selected by the 3-bit read pointer, so out follows state with no
// bypass from in. Overflow and underflow attempts latch sticky flags.
module fifo8x16 (
    input  logic        clk,
    input  logic        reset,
    fifo8x16_if.slave   bus
);
    logic [15:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count_q;
    logic        ovf_q;
    logic        udf_q;

    logic        full_w;
    logic        empty_w;
    logic        push_ok;
    logic        pop_ok;

    assign full_w  = (count_q == 4'd8);
    assign empty_w = (count_q == 4'd0);

    // A push while full is still accepted when a pop frees the head slot
    // in the same cycle; a pop while empty is never accepted.
    assign push_ok = bus.push & (~full_w | bus.pop);
    assign pop_ok  = bus.pop & ~empty_w;

    // Register bank, pointers, occupancy count and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 16'h0000;
            end
            wr_ptr  <= 3'd0;
            rd_ptr  <= 3'd0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= bus.in;
                wr_ptr      <= wr_ptr + 3'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
            if (bus.push & ~push_ok) begin
                ovf_q <= 1'b1;
            end
            if (bus.pop & empty_w) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.out   = mem[rd_ptr];
    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule

// File: tb/tb_fifo8x16.sv
// Self-checking bench for fifo8x16: directed boundary scenarios followed by
// a random push/pop phase, all checked against a queue-based scoreboard.
module tb_fifo8x16;
    logic clk;
    logic reset;

    fifo8x16_if bus ();

    fifo8x16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [15:0] exp_q[$];
    logic        exp_ovf;
    logic        exp_udf;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Compare all status outputs against the scoreboard; the head word is
    // only defined while the FIFO holds data.
    task automatic check_status();
        int n;
        n = exp_q.size();
        check("count", {12'h000, bus.count}, 16'(n));
        check("empty", {15'h0, bus.empty}, {15'h0, n == 0});
        check("full",  {15'h0, bus.full},  {15'h0, n == 8});
        check("ovf",   {15'h0, bus.ovf},   {15'h0, exp_ovf});
        check("udf",   {15'h0, bus.udf},   {15'h0, exp_udf});
        if (n > 0) begin
            check("head", bus.out, exp_q[0]);
        end
    endtask

    // One clock cycle with the given requests; inputs are applied 1 time unit
    // after the previous rising edge and outputs sampled 1 unit after the next.
    task automatic step(input logic p, input logic q, input logic [15:0] d);
        int          n;
        logic        push_ok;
        logic        pop_ok;
        logic [15:0] exp_word;
        n = exp_q.size();
        bus.push = p;
        bus.pop  = q;
        bus.in   = d;
        pop_ok  = q && (n > 0);
        push_ok = p && ((n < 8) || q);
        if (pop_ok) begin
            exp_word = exp_q.pop_front();
            check("pop_data", bus.out, exp_word);
        end
        if (push_ok) exp_q.push_back(d);
        if (p && !push_ok) exp_ovf = 1'b1;
        if (q && (n == 0)) exp_udf = 1'b1;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check_status();
    endtask

    // Reset edge, optionally with a push request that must be ignored.
    task automatic do_reset(input logic p, input logic [15:0] d);
        reset    = 1'b1;
        bus.push = p;
        bus.pop  = 1'b0;
        bus.in   = d;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.push = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        check("reset_out", bus.out, 16'h0000);
        check_status();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = 16'h0000;
        @(posedge clk);
        #1;

        // Reset then idle
        do_reset(1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);

        // Fill and drain
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
        check("fill_out", bus.out, 16'h0001);
        // Overflow from full: push alone is dropped
        step(1'b1, 1'b0, 16'hBEEF);
        check("ovf_out", bus.out, 16'h0001);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000);

        // Underflow, then push+pop on empty
        step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 16'h1234);
        check("empty_pp_out", bus.out, 16'h1234);
        step(1'b0, 1'b1, 16'h0000);

        // Wrap and full push+pop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h5000 + 16'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
        check("wrap_out", bus.out, 16'hA000);
        step(1'b1, 1'b1, 16'hC0DE);
        check("full_pp_out", bus.out, 16'hA001);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535)));
        end

        // Reset mid-operation with count=5 and ovf set
        do_reset(1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h7000 + 16'(i));
        step(1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000);
        check("pre_reset_count", {12'h000, bus.count}, 16'd5);
        do_reset(1'b1, 16'h5555);
        step(1'b0, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo8x16.md
Name: fifo8x16

Overview:
- 8-entry, 16-bit synchronous FIFO that stores words in an 8x16 register bank.
- Read data is selected combinationally by the read pointer through an 8-way 16-bit multiplexer; the 3-bit read pointer is that multiplexer's select.
- Sits upstream of the 8-way mux read path and buffers words between a producer and a consumer in the same clock domain.
- Show-ahead: the head word is always visible on out.

Parameters:
- None. Depth fixed at 8, width fixed at 16.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  16  write data
- push  input  1  write request; in captured at clk edge when accepted
- pop  input  1  read request; head entry discarded at clk edge when accepted
- out  output  16  head-of-queue data (mem[rd_ptr]), combinational from state
- empty  output  1  count == 0
- full  output  1  count == 8
- count  output  4  number of stored words, 0..8
- ovf  output  1  sticky: push attempted while full and not accepted
- udf  output  1  sticky: pop attempted while empty

Behaviour:
- State: mem[0..7] (16b each), wr_ptr (3b), rd_ptr (3b), count (4b), ovf, udf.
- Reset, at clk edge with reset=1, overriding push/pop:
  - wr_ptr=0, rd_ptr=0, count=0.
  - all mem=0.
  - ovf=0, udf=0.
  - Therefore out=0, empty=1, full=0.
- Accept rules, evaluated each cycle on the pre-edge state:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- On push_ok: mem[wr_ptr] <= in; wr_ptr <= wr_ptr+1, wrapping modulo 8 (7 -> 0).
- On pop_ok: rd_ptr <= rd_ptr+1, wrapping modulo 8. The popped mem entry is not cleared.
- count update:
  - +1 if push_ok & ~pop_ok
  - -1 if pop_ok & ~push_ok
  - unchanged otherwise
- Boundary cases:
  - Empty + push + pop: pop ignored, push accepted, count 0 -> 1, udf set.
  - Full + push + pop: both accepted, count stays 8. The write lands in the slot vacated by the pop (wr_ptr == rd_ptr when full).
  - Full + push only: push dropped, mem and pointers unchanged, ovf set.
  - Empty + pop only: no state change except udf set.
- ovf/udf remain 1 until reset.
- Latency:
  - A word pushed into an empty FIFO appears on out in the cycle after the push edge.
  - out updates combinationally after each pop edge to the next entry.
  - There is no same-cycle bypass from in to out.
- out = mem[rd_ptr] via a 3-bit select 8:1 mux. When empty, out shows the stale mem[rd_ptr] value; consumers gate on ~empty.
- full and empty are decoded from count, never both 1.
- Reset asserted mid-burst discards all contents on that edge, regardless of push/pop.

Test Plan:
- Reset then idle: assert reset for 1 cycle -> out=0x0000, count=0, empty=1, full=0, ovf=0, udf=0.
- Fill and drain:
  - push 0x0001..0x0008 on 8 consecutive cycles -> count=8, full=1, out=0x0001.
  - Then pop 8 cycles -> out sequence 0x0001..0x0008, final empty=1, count=0.
- Overflow:
  - From full, push 0xBEEF alone -> count stays 8, ovf=1, out unchanged.
  - A later drain yields no 0xBEEF.
- Underflow and empty push+pop:
  - Pop on empty -> udf=1, count=0.
  - Then push 0x1234 with pop=1 on empty -> count=1, out=0x1234.
- Wrap and full push+pop:
  - Push 5, pop 5, then push 0xA000..0xA007 -> wr_ptr wraps through 7 -> 0, full=1, out=0xA000.
  - Then push 0xC0DE with pop=1 -> count=8, out=0xA001.
  - Draining returns 0xA001..0xA007, then 0xC0DE.
- Reset mid-operation:
  - With count=5 and ovf=1, assert reset together with push=1 -> count=0, empty=1, ovf=0, out=0x0000.
  - The pushed word is not stored.
